// File: rtl/row_ser_pkg.sv
// Shared sizing defaults, helpers and FSM encoding for the row stream serializer.
package row_ser_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_COL        = 64;
    localparam int DEF_ROW        = 256;
    localparam int DEF_LANES      = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beats_of(input int col, input int lanes);
        return col / lanes;
    endfunction

endpackage

// File: rtl/row_stream_serializer_fifo.sv
// Register FIFO of whole rows; push and pop may coincide even when full.
module row_fifo
    import row_ser_pkg::*;
#(
    parameter int DW    = DEF_WIDTH * DEF_COL,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int PTR_W = width_of(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic [DW-1:0]  din,
    output logic [DW-1:0]  dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] occupancy
);

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occupancy <= occupancy + 1'b1;
            else if (pop && !push) occupancy <= occupancy - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Head comes straight from the storage flops: a row written this cycle is
    // only visible after the edge, so there is no path from din to dout.
    assign dout  = mem[rd_ptr];
    assign full  = (occupancy == (PTR_W+1)'(DEPTH));
    assign empty = (occupancy == '0);

endmodule

// File: rtl/row_stream_serializer.sv
// Buffers full rows and streams them as LANES-wide beats with row/matrix markers.
// Optional drop tracking enabled by macro ROW_SER_OVERFLOW_TRACK_EN.
module row_stream_serializer
    import row_ser_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int COL        = DEF_COL,
    parameter int ROW        = DEF_ROW,
    parameter int LANES      = DEF_LANES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [WIDTH*COL-1:0]     in_row,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH*LANES-1:0]   m_data,
    output logic                     m_last_row,
    output logic                     m_last_mat,
    output logic [$clog2(ROW)-1:0]   row_count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int BEATS     = beats_of(COL, LANES);
    localparam int BEAT_W    = width_of(BEATS);
    localparam int PTR_W     = width_of(FIFO_DEPTH);
    localparam int ROWCNT_W  = $clog2(ROW);
    localparam int BEAT_BITS = WIDTH * LANES;

    state_t               state;
    state_t               state_next;
    logic [BEAT_W-1:0]    beat;
    logic [WIDTH*COL-1:0] shreg;
    logic [WIDTH*COL-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PTR_W:0]       fifo_occ;
    logic                 last_beat;
    logic                 take;
    logic                 pop;
    logic                 push;
    logic                 drop;

    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign take      = en && (state == STREAM) && m_ready;
    assign push      = en && in_valid && ((fifo_occ < (PTR_W+1)'(FIFO_DEPTH)) || pop);
    assign drop      = en && in_valid && fifo_full && !pop;

    row_fifo #(
        .DW    (WIDTH * COL),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (in_row),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A new row is fetched either from idle or as the last beat of the
    // current row is taken, which keeps consecutive rows bubble-free.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    pop        = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (take && last_beat) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            beat      <= '0;
            row_count <= '0;
        end else begin
            if (pop) begin
                shreg <= fifo_dout;
                beat  <= '0;
            end else if (take) begin
                shreg <= shreg >> BEAT_BITS;
                beat  <= last_beat ? '0 : beat + 1'b1;
            end
            if (take && last_beat)
                row_count <= (row_count == ROWCNT_W'(ROW - 1)) ? '0 : row_count + 1'b1;
        end
    end

    assign m_valid    = (state == STREAM);
    assign m_data     = shreg[BEAT_BITS-1:0];
    assign m_last_row = m_valid && last_beat;
    assign m_last_mat = m_last_row && (row_count == ROWCNT_W'(ROW - 1));

`ifdef ROW_SER_OVERFLOW_TRACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign overflow    = 1'b0;
    assign drop_count  = '0;
`endif

endmodule
